// File: rtl/axi_full_mst_burst.sv
// Single-outstanding AXI4 master: one command becomes one INCR burst on MEM_*.
// Write/read beats pass straight through between the streams and the AXI channels.
module axi_full_mst_burst #(
  parameter int unsigned DW = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WR,
  input  logic [31:0]   CMD_ADDR,
  input  logic [7:0]    CMD_LEN,
  input  logic          WD_VALID,
  output logic          WD_READY,
  input  logic [DW-1:0] WD_DATA,
  input  logic [7:0]    WD_STRB,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_LAST,
  output logic          DONE_VALID,
  input  logic          DONE_READY,
  output logic [1:0]    DONE_RESP,
  output logic          DONE_LASTERR,
  output logic [31:0]   MEM_AWADDR,
  output logic [7:0]    MEM_AWLEN,
  output logic [2:0]    MEM_AWSIZE,
  output logic [1:0]    MEM_AWBURST,
  output logic          MEM_AWVALID,
  input  logic          MEM_AWREADY,
  output logic [DW-1:0] MEM_WDATA,
  output logic [7:0]    MEM_WSTRB,
  output logic          MEM_WLAST,
  output logic          MEM_WVALID,
  input  logic          MEM_WREADY,
  input  logic [1:0]    MEM_BRESP,
  input  logic          MEM_BVALID,
  output logic          MEM_BREADY,
  output logic [31:0]   MEM_ARADDR,
  output logic [7:0]    MEM_ARLEN,
  output logic [2:0]    MEM_ARSIZE,
  output logic [1:0]    MEM_ARBURST,
  output logic          MEM_ARVALID,
  input  logic          MEM_ARREADY,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic [1:0]    MEM_RRESP,
  input  logic          MEM_RLAST,
  input  logic          MEM_RVALID,
  output logic          MEM_RREADY
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [1:0]    resp_q, resp_d;
  logic          lasterr_q, lasterr_d;
  logic          last_beat;
  logic          w_beat;
  logic          r_beat;

  // Address bits below the 8-byte beat are dropped on capture.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^CMD_ADDR[2:0];

  assign last_beat = (cnt_q == len_q);
  assign w_beat    = (state_q == S_W) && WD_VALID && MEM_WREADY;
  assign r_beat    = (state_q == S_R) && MEM_RVALID && RD_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      resp_q    <= '0;
      lasterr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      lasterr_q <= lasterr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    lasterr_d = lasterr_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          addr_d    = {CMD_ADDR[AW-1:3], 3'b000};
          len_d     = CMD_LEN;
          cnt_d     = '0;
          resp_d    = '0;
          lasterr_d = 1'b0;
          state_d   = CMD_WR ? S_AW : S_AR;
        end
      end
      S_AW: if (MEM_AWREADY) state_d = S_W;
      S_W: begin
        if (w_beat) begin
          cnt_d = LW'(cnt_q + LW'(1));
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        if (MEM_BVALID) begin
          resp_d  = MEM_BRESP;
          state_d = S_DONE;
        end
      end
      S_AR: if (MEM_ARREADY) state_d = S_R;
      S_R: begin
        // Worst response wins; slave RLAST is only cross-checked against our count.
        if (r_beat) begin
          if (MEM_RRESP > resp_q) resp_d = MEM_RRESP;
          if (MEM_RLAST != last_beat) lasterr_d = 1'b1;
          cnt_d = LW'(cnt_q + LW'(1));
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: if (DONE_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign CMD_READY    = (state_q == S_IDLE);

  assign MEM_AWADDR   = addr_q;
  assign MEM_AWLEN    = len_q;
  assign MEM_AWSIZE   = 3'd3;
  assign MEM_AWBURST  = 2'b01;
  assign MEM_AWVALID  = (state_q == S_AW);

  assign MEM_WVALID   = (state_q == S_W) && WD_VALID;
  assign WD_READY     = (state_q == S_W) && MEM_WREADY;
  assign MEM_WDATA    = WD_DATA;
  assign MEM_WSTRB    = WD_STRB;
  assign MEM_WLAST    = (state_q == S_W) && last_beat;

  assign MEM_BREADY   = (state_q == S_B);

  assign MEM_ARADDR   = addr_q;
  assign MEM_ARLEN    = len_q;
  assign MEM_ARSIZE   = 3'd3;
  assign MEM_ARBURST  = 2'b01;
  assign MEM_ARVALID  = (state_q == S_AR);

  assign RD_VALID     = (state_q == S_R) && MEM_RVALID;
  assign MEM_RREADY   = (state_q == S_R) && RD_READY;
  assign RD_DATA      = MEM_RDATA;
  assign RD_LAST      = (state_q == S_R) && last_beat;

  assign DONE_VALID   = (state_q == S_DONE);
  assign DONE_RESP    = resp_q;
  assign DONE_LASTERR = lasterr_q;

endmodule

// File: tb/tb_axi_full_mst_burst.sv
// Bench for axi_full_mst_burst: table of burst commands against a small SRAM slave
// model, plus hand sequences for held-command and mid-burst reset cases.
module tb_axi_full_mst_burst;

  localparam int unsigned DW     = 64;
  localparam int          BUDGET = 200;

  logic          CLK, RST;
  logic          CMD_VALID, CMD_READY, CMD_WR;
  logic [31:0]   CMD_ADDR;
  logic [7:0]    CMD_LEN;
  logic          WD_VALID, WD_READY;
  logic [DW-1:0] WD_DATA;
  logic [7:0]    WD_STRB;
  logic          RD_VALID, RD_READY, RD_LAST;
  logic [DW-1:0] RD_DATA;
  logic          DONE_VALID, DONE_READY, DONE_LASTERR;
  logic [1:0]    DONE_RESP;
  logic [31:0]   MEM_AWADDR, MEM_ARADDR;
  logic [7:0]    MEM_AWLEN, MEM_ARLEN;
  logic [2:0]    MEM_AWSIZE, MEM_ARSIZE;
  logic [1:0]    MEM_AWBURST, MEM_ARBURST;
  logic          MEM_AWVALID, MEM_AWREADY, MEM_ARVALID, MEM_ARREADY;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;
  logic [7:0]    MEM_WSTRB;
  logic          MEM_WLAST, MEM_WVALID, MEM_WREADY;
  logic [1:0]    MEM_BRESP, MEM_RRESP;
  logic          MEM_BVALID, MEM_BREADY;
  logic          MEM_RLAST, MEM_RVALID, MEM_RREADY;

  int n_run  = 0;
  int n_fail = 0;

  axi_full_mst_burst #(.DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA), .WD_STRB(WD_STRB),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
    .DONE_VALID(DONE_VALID), .DONE_READY(DONE_READY), .DONE_RESP(DONE_RESP),
    .DONE_LASTERR(DONE_LASTERR),
    .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN), .MEM_AWSIZE(MEM_AWSIZE),
    .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN), .MEM_ARSIZE(MEM_ARSIZE),
    .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
    .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM slave model: one wait state on AW/AR, optional random WREADY, error injection.
  bit          slv_gaps, slv_err;
  logic [63:0] mem [256];
  logic        aw_rdy, w_act, w_rnd, b_v, ar_rdy, r_act;
  logic [7:0]  w_base, w_cnt, w_len, r_base, r_cnt, r_len;
  logic [7:0]  w_idx, r_idx;

  assign w_idx       = 8'(w_base + w_cnt);
  assign r_idx       = 8'(r_base + r_cnt);
  assign MEM_AWREADY = aw_rdy;
  assign MEM_WREADY  = w_act & w_rnd;
  assign MEM_BVALID  = b_v;
  assign MEM_BRESP   = 2'd0;
  assign MEM_ARREADY = ar_rdy;
  assign MEM_RVALID  = r_act;
  assign MEM_RDATA   = mem[r_idx];
  assign MEM_RRESP   = (slv_err && r_cnt == 8'd2) ? 2'd2 : 2'd0;
  assign MEM_RLAST   = slv_err ? (r_cnt == 8'd1) : (r_cnt == r_len);

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      aw_rdy <= 1'b0; w_act <= 1'b0; w_rnd <= 1'b0; b_v <= 1'b0;
      ar_rdy <= 1'b0; r_act <= 1'b0;
      w_base <= '0; w_cnt <= '0; w_len <= '0;
      r_base <= '0; r_cnt <= '0; r_len <= '0;
    end else begin
      w_rnd <= slv_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (MEM_AWVALID && !w_act && !b_v) begin
        if (aw_rdy) begin
          w_base <= MEM_AWADDR[10:3]; w_len <= MEM_AWLEN; w_cnt <= '0;
          w_act <= 1'b1; aw_rdy <= 1'b0;
        end else aw_rdy <= 1'b1;
      end
      if (MEM_WVALID && MEM_WREADY) begin
        mem[w_idx] <= (mem[w_idx] & ~strb_mask(MEM_WSTRB)) | (MEM_WDATA & strb_mask(MEM_WSTRB));
        w_cnt <= 8'(w_cnt + 8'd1);
        if (w_cnt == w_len) begin
          w_act <= 1'b0; b_v <= 1'b1;
        end
      end
      if (b_v && MEM_BREADY) b_v <= 1'b0;
      if (MEM_ARVALID && !r_act) begin
        if (ar_rdy) begin
          r_base <= MEM_ARADDR[10:3]; r_len <= MEM_ARLEN; r_cnt <= '0;
          r_act <= 1'b1; ar_rdy <= 1'b0;
        end else ar_rdy <= 1'b1;
      end
      if (MEM_RVALID && MEM_RREADY) begin
        r_cnt <= 8'(r_cnt + 8'd1);
        if (r_cnt == r_len) r_act <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [63:0] seed, input int i);
    return 64'(seed * 64'(i + 1));
  endfunction

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
    int k;
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_WR = wr; CMD_ADDR = addr; CMD_LEN = len;
    #1;
    k = 0;
    while (!CMD_READY && k < BUDGET) begin
      @(negedge CLK); #1; k++;
    end
    check("cmd_ready", 64'(CMD_READY), 64'd1);
  endtask

  task automatic addr_phase(input bit wr, input logic [31:0] exp_addr,
                            input logic [7:0] len, input bit hold);
    logic [31:0] prev_addr;
    bit waited, done;
    waited = 1'b0; done = 1'b0; prev_addr = '0;
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge CLK);
      if (!hold) CMD_VALID = 1'b0;
      if (wr) WD_VALID = 1'b1;
      #1;
      if (wr) begin
        if (k == 0) begin
          check("awvalid_n1", 64'(MEM_AWVALID), 64'd1);
          check("awaddr", 64'(MEM_AWADDR), 64'(exp_addr));
          check("awlen", 64'(MEM_AWLEN), 64'(len));
          check("awsize_burst", 64'({MEM_AWSIZE, MEM_AWBURST}), 64'({3'd3, 2'b01}));
        end
        check("wvalid_before_aw", 64'(MEM_WVALID), 64'd0);
        if (waited) check("aw_stable", 64'({MEM_AWVALID, MEM_AWADDR, MEM_AWLEN}),
                          64'({1'b1, prev_addr, len}));
        waited = MEM_AWVALID && !MEM_AWREADY;
        prev_addr = MEM_AWADDR;
        done = MEM_AWVALID && MEM_AWREADY;
      end else begin
        if (k == 0) begin
          check("arvalid_n1", 64'(MEM_ARVALID), 64'd1);
          check("araddr", 64'(MEM_ARADDR), 64'(exp_addr));
          check("arlen", 64'(MEM_ARLEN), 64'(len));
          check("arsize_burst", 64'({MEM_ARSIZE, MEM_ARBURST}), 64'({3'd3, 2'b01}));
        end
        if (waited) check("ar_stable", 64'({MEM_ARVALID, MEM_ARADDR, MEM_ARLEN}),
                          64'({1'b1, prev_addr, len}));
        waited = MEM_ARVALID && !MEM_ARREADY;
        prev_addr = MEM_ARADDR;
        done = MEM_ARVALID && MEM_ARREADY;
      end
    end
    if (!done) check("addr_timeout", 64'd0, 64'd1);
  endtask

  task automatic write_beats(input logic [63:0] seed, input logic [7:0] len,
                             input bit gaps, input int stop);
    int i;
    i = 0;
    for (int k = 0; k < BUDGET && i < stop; k++) begin
      @(negedge CLK);
      WD_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      WD_DATA  = beat_data(seed, i);
      WD_STRB  = 8'hFF;
      #1;
      if (WD_VALID && WD_READY) begin
        check("wvalid", 64'(MEM_WVALID), 64'd1);
        check("wdata", MEM_WDATA, beat_data(seed, i));
        check("wlast", 64'(MEM_WLAST), 64'(i == int'(len)));
        i++;
      end
    end
    if (i < stop) check("w_beats_timeout", 64'(i), 64'(stop));
  endtask

  task automatic wait_b();
    bit done;
    done = 1'b0;
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge CLK); WD_VALID = 1'b0; #1;
      if (k == 0) check("bready", 64'(MEM_BREADY), 64'd1);
      done = MEM_BVALID && MEM_BREADY;
    end
    if (!done) check("b_timeout", 64'd0, 64'd1);
  endtask

  task automatic read_beats(input logic [63:0] seed, input logic [7:0] len, input bit gaps);
    int i;
    bit waited;
    logic [63:0] prev;
    i = 0; waited = 1'b0; prev = '0;
    for (int k = 0; k < BUDGET && i <= int'(len); k++) begin
      @(negedge CLK);
      RD_READY = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (waited) begin
        check("rd_hold_valid", 64'(RD_VALID), 64'd1);
        check("rd_hold_data", RD_DATA, prev);
      end
      waited = RD_VALID && !RD_READY;
      prev = RD_DATA;
      if (RD_VALID && RD_READY) begin
        check("rd_data", RD_DATA, beat_data(seed, i));
        check("rd_last", 64'(RD_LAST), 64'(i == int'(len)));
        i++;
      end
    end
    if (i <= int'(len)) check("r_beats_timeout", 64'(i), 64'(len) + 64'd1);
  endtask

  task automatic finish_done(input logic [1:0] exp_resp, input bit exp_lasterr);
    @(negedge CLK);
    RD_READY = 1'b0; WD_VALID = 1'b0;
    #1;
    check("done_valid_k1", 64'(DONE_VALID), 64'd1);
    check("done_resp", 64'(DONE_RESP), 64'(exp_resp));
    check("done_lasterr", 64'(DONE_LASTERR), 64'(exp_lasterr));
    check("no_extra_rd", 64'(RD_VALID), 64'd0);
    DONE_READY = 1'b1;
    @(negedge CLK);
    DONE_READY = 1'b0;
    #1;
    check("cmd_ready_j1", 64'({CMD_READY, DONE_VALID}), 64'({1'b1, 1'b0}));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [63:0] seed;
    bit          gaps;
    bit          err;
    logic [31:0] exp_addr;
    logic [1:0]  exp_resp;
    bit          exp_lasterr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    slv_gaps = v.gaps;
    slv_err  = v.err;
    issue_cmd(v.wr, v.addr, v.len);
    addr_phase(v.wr, v.exp_addr, v.len, 1'b0);
    if (v.wr) begin
      write_beats(v.seed, v.len, v.gaps, int'(v.len) + 1);
      wait_b();
    end else begin
      read_beats(v.seed, v.len, v.gaps);
    end
    finish_done(v.exp_resp, v.exp_lasterr);
    slv_err = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h80,  8'd3,  64'h11, 1'b0, 1'b0, 32'h80,  2'd0, 1'b0};
    vecs[1] = '{1'b0, 32'h80,  8'd3,  64'h11, 1'b0, 1'b0, 32'h80,  2'd0, 1'b0};
    vecs[2] = '{1'b1, 32'h1F,  8'd0,  64'hA5A5_0000_0000_0018, 1'b0, 1'b0, 32'h18, 2'd0, 1'b0};
    vecs[3] = '{1'b0, 32'h1F,  8'd0,  64'hA5A5_0000_0000_0018, 1'b0, 1'b0, 32'h18, 2'd0, 1'b0};
    vecs[4] = '{1'b1, 32'h200, 8'd15, 64'h0101_0101_0000_0001, 1'b1, 1'b0, 32'h200, 2'd0, 1'b0};
    vecs[5] = '{1'b0, 32'h200, 8'd15, 64'h0101_0101_0000_0001, 1'b1, 1'b0, 32'h200, 2'd0, 1'b0};
    vecs[6] = '{1'b0, 32'h80,  8'd3,  64'h11, 1'b0, 1'b1, 32'h80,  2'd2, 1'b1};
    vecs[7] = '{1'b1, 32'h300, 8'd1,  64'h0BAD_F00D_0000_0003, 1'b0, 1'b0, 32'h300, 2'd0, 1'b0};
    vecs[8] = '{1'b0, 32'h300, 8'd1,  64'h0BAD_F00D_0000_0003, 1'b0, 1'b0, 32'h300, 2'd0, 1'b0};

    RST = 1'b1;
    CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_ADDR = '0; CMD_LEN = '0;
    WD_VALID = 1'b0; WD_DATA = '0; WD_STRB = '0;
    RD_READY = 1'b0; DONE_READY = 1'b0;
    slv_gaps = 1'b0; slv_err = 1'b0;

    repeat (3) @(negedge CLK);
    #1;
    check("reset_handshake", 64'({MEM_AWVALID, MEM_WVALID, MEM_ARVALID, RD_VALID, DONE_VALID,
                                  MEM_BREADY, MEM_RREADY, CMD_READY}), 64'(8'b0000_0001));
    check("reset_regs", 64'({MEM_AWADDR, MEM_AWLEN, DONE_RESP, DONE_LASTERR}), 64'd0);
    RST = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Command held through DONE: taken only once the block is back in IDLE.
    issue_cmd(1'b0, 32'h18, 8'd0);
    addr_phase(1'b0, 32'h18, 8'd0, 1'b1);
    read_beats(64'hA5A5_0000_0000_0018, 8'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); RD_READY = 1'b0; #1;
      check("held_cmd_in_done", 64'({DONE_VALID, CMD_READY}), 64'({1'b1, 1'b0}));
    end
    DONE_READY = 1'b1;
    @(negedge CLK); DONE_READY = 1'b0; #1;
    check("held_cmd_idle", 64'({CMD_READY, MEM_ARVALID}), 64'({1'b1, 1'b0}));
    addr_phase(1'b0, 32'h18, 8'd0, 1'b0);
    read_beats(64'hA5A5_0000_0000_0018, 8'd0, 1'b0);
    finish_done(2'd0, 1'b0);

    // Reset in the middle of a write burst, then a clean write/read pair.
    issue_cmd(1'b1, 32'h300, 8'd7);
    addr_phase(1'b1, 32'h300, 8'd7, 1'b0);
    write_beats(64'h77, 8'd7, 1'b0, 3);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); #1;
    check("midburst_reset", 64'({MEM_AWVALID, MEM_WVALID, MEM_ARVALID, RD_VALID, DONE_VALID,
                                 MEM_BREADY, MEM_RREADY, CMD_READY}), 64'(8'b0000_0001));
    RST = 1'b0; WD_VALID = 1'b0;
    run_vec(vecs[7]);
    run_vec(vecs[8]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
